// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU MEM
// stage and an external load/debug port. Each grant owns DM for MEM_LAT cycles.
module dm_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              dm_re,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic {Idle, Access} state_t;

  localparam logic [2:0] CntInit = 3'(MEM_LAT - 1);

  state_t     state;
  logic       lastGrant;  // 0 = CPU, 1 = EXT
  logic       owner;
  logic       weLatch;
  logic [2:0] cnt;

  logic cpuElig;
  logic extElig;
  logic grantAny;
  logic grantExt;
  logic grantWe;

  assign cpu_stall = cpu_req & ~cpu_ack;

  // A requester in its ack cycle is not eligible, so it cannot be re-granted
  // on the stale request it is still holding.
  assign cpuElig  = cpu_req & ~cpu_ack;
  assign extElig  = ext_req & ~ext_ack;
  assign grantAny = cpuElig | extElig;
  assign grantExt = extElig & (~cpuElig | ~lastGrant);
  assign grantWe  = grantExt ? ext_we : cpu_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= Idle;
      lastGrant <= 1'b1;
      owner     <= 1'b0;
      weLatch   <= 1'b0;
      cnt       <= 3'd0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
      dm_re     <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ext_ack <= 1'b0;
      unique case (state)
        Idle: begin
          if (grantAny) begin
            owner     <= grantExt;
            lastGrant <= grantExt;
            weLatch   <= grantWe;
            dm_addr   <= grantExt ? ext_addr : cpu_addr;
            dm_wdata  <= grantExt ? ext_wdata : cpu_wdata;
            dm_we     <= grantWe;
            dm_re     <= ~grantWe;
            cnt       <= CntInit;
            state     <= Access;
          end
        end
        Access: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            if (!weLatch) begin
              if (owner) ext_rdata <= dm_rdata;
              else       cpu_rdata <= dm_rdata;
            end
            if (owner) ext_ack <= 1'b1;
            else       cpu_ack <= 1'b1;
            dm_re <= 1'b0;
            dm_we <= 1'b0;
            state <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a MEM_LAT=1 instance for the basic read, a MEM_LAT=3
// instance for everything else, with a scoreboard of expected acks.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic        isExt;
    logic        isRead;
    logic [15:0] data;
  } sbItem_t;

  sbItem_t sbq[$];
  sbItem_t item;

  // MEM_LAT = 1 instance
  logic        aCpuReq = 0, aCpuWe = 0, aCpuAck, aCpuStall;
  logic [15:0] aCpuAddr = 0, aCpuWdata = 0, aCpuRdata;
  logic        aExtReq = 0, aExtWe = 0, aExtAck;
  logic [15:0] aExtAddr = 0, aExtWdata = 0, aExtRdata;
  logic        aDmRe, aDmWe;
  logic [15:0] aDmAddr, aDmWdata, aDmRdata;

  // MEM_LAT = 3 instance
  logic        cpuReq = 0, cpuWe = 0, cpuAck, cpuStall;
  logic [15:0] cpuAddr = 0, cpuWdata = 0, cpuRdata;
  logic        extReq = 0, extWe = 0, extAck;
  logic [15:0] extAddr = 0, extWdata = 0, extRdata;
  logic        dmRe, dmWe;
  logic [15:0] dmAddr, dmWdata, dmRdata;

  logic [15:0] mem1 [0:1023];
  logic [15:0] mem3 [0:1023];

  assign aDmRdata = mem1[aDmAddr[9:0]];
  assign dmRdata  = mem3[dmAddr[9:0]];

  always @(posedge clk) begin
    if (rst) begin
      mem1[10'h010] <= 16'hBEEF;
      mem3[10'h200] <= 16'hC0DE;
      mem3[10'h300] <= 16'hE0E0;
    end else begin
      if (aDmWe) mem1[aDmAddr[9:0]] <= aDmWdata;
      if (dmWe)  mem3[dmAddr[9:0]]  <= dmWdata;
    end
  end

  dm_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(aCpuReq), .cpu_we(aCpuWe), .cpu_addr(aCpuAddr), .cpu_wdata(aCpuWdata),
    .cpu_rdata(aCpuRdata), .cpu_ack(aCpuAck), .cpu_stall(aCpuStall),
    .ext_req(aExtReq), .ext_we(aExtWe), .ext_addr(aExtAddr), .ext_wdata(aExtWdata),
    .ext_rdata(aExtRdata), .ext_ack(aExtAck),
    .dm_re(aDmRe), .dm_we(aDmWe), .dm_addr(aDmAddr), .dm_wdata(aDmWdata),
    .dm_rdata(aDmRdata)
  );

  dm_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdata), .cpu_ack(cpuAck), .cpu_stall(cpuStall),
    .ext_req(extReq), .ext_we(extWe), .ext_addr(extAddr), .ext_wdata(extWdata),
    .ext_rdata(extRdata), .ext_ack(extAck),
    .dm_re(dmRe), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_rdata(dmRdata)
  );

  function automatic void pushExp(input logic isExt, input logic isRead, input logic [15:0] d);
    sbItem_t e;
    e.isExt  = isExt;
    e.isRead = isRead;
    e.data   = d;
    sbq.push_back(e);
  endfunction

  // Scoreboard and invariants on the MEM_LAT=3 instance
  always @(negedge clk) begin
    if (!rst) begin
      checkCount++;
      if (cpuAck && extAck) $display("FAIL ack_overlap: cpu_ack=%b ext_ack=%b", cpuAck, extAck);
      else passCount++;
      checkCount++;
      if (dmRe && dmWe) $display("FAIL strobe_overlap: dm_re=%b dm_we=%b", dmRe, dmWe);
      else passCount++;
      if (cpuAck || extAck) begin
        checkCount++;
        if (sbq.size() == 0) begin
          $display("FAIL sb_unexpected_ack: cpu_ack=%b ext_ack=%b, none expected", cpuAck, extAck);
        end else begin
          item = sbq.pop_front();
          if (extAck !== item.isExt) begin
            $display("FAIL sb_owner: ext_ack=%b expected %b", extAck, item.isExt);
          end else begin
            passCount++;
            if (item.isRead) begin
              checkCount++;
              if ((item.isExt ? extRdata : cpuRdata) !== item.data)
                $display("FAIL sb_rdata: got %h expected %h",
                         item.isExt ? extRdata : cpuRdata, item.data);
              else passCount++;
            end
          end
        end
      end
    end
  end

  task automatic access(input logic isExt, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int ackCyc, output int reCnt,
                        output int weCnt, output int stallCnt);
    ackCyc = -1; reCnt = 0; weCnt = 0; stallCnt = 0;
    @(posedge clk); #1;
    if (isExt) begin extReq = 1; extWe = we; extAddr = addr; extWdata = wdata; end
    else       begin cpuReq = 1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata; end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dmRe) reCnt++;
      if (dmWe) weCnt++;
      if (cpuStall) stallCnt++;
      if (isExt ? extAck : cpuAck) begin ackCyc = c; break; end
    end
    @(posedge clk); #1;
    if (isExt) extReq = 0; else cpuReq = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checkCount++;
    if ({cpuAck, extAck, dmRe, dmWe, aCpuAck, aExtAck, aDmRe, aDmWe} !== 8'h00)
      $display("FAIL reset_strobes: got %b expected 00000000",
               {cpuAck, extAck, dmRe, dmWe, aCpuAck, aExtAck, aDmRe, aDmWe});
    else passCount++;
    checkCount++;
    if ({cpuRdata, extRdata, dmAddr, dmWdata} !== 64'h0)
      $display("FAIL reset_data: got %h expected 0", {cpuRdata, extRdata, dmAddr, dmWdata});
    else passCount++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_lat1_read();
    int ackCyc = -1, reCnt = 0, stallCnt = 0;
    logic [15:0] rd = '0;
    @(posedge clk); #1;
    aCpuReq = 1; aCpuWe = 0; aCpuAddr = 16'h0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (aDmRe) reCnt++;
      if (aCpuStall) stallCnt++;
      if (aCpuAck) begin ackCyc = c; rd = aCpuRdata; break; end
    end
    @(posedge clk); #1;
    aCpuReq = 0;
    checkCount++;
    if (ackCyc !== 2) $display("FAIL lat1_ack_cycle: got %0d expected 2", ackCyc);
    else passCount++;
    checkCount++;
    if (reCnt !== 1) $display("FAIL lat1_re_cycles: got %0d expected 1", reCnt);
    else passCount++;
    checkCount++;
    if (stallCnt !== 2) $display("FAIL lat1_stall_cycles: got %0d expected 2", stallCnt);
    else passCount++;
    checkCount++;
    if (rd !== 16'hBEEF) $display("FAIL lat1_rdata: got %h expected beef", rd);
    else passCount++;
  endtask

  task automatic test_write_read();
    int ackCyc, reCnt, weCnt, stallCnt;
    pushExp(1'b1, 1'b0, 16'h0000);
    access(1'b1, 1'b1, 16'h0100, 16'h1234, ackCyc, reCnt, weCnt, stallCnt);
    checkCount++;
    if (weCnt !== 3) $display("FAIL wr_we_cycles: got %0d expected 3", weCnt);
    else passCount++;
    checkCount++;
    if (ackCyc !== 4) $display("FAIL wr_ack_cycle: got %0d expected 4", ackCyc);
    else passCount++;
    checkCount++;
    if (extRdata !== 16'h0000) $display("FAIL wr_rdata_kept: got %h expected 0000", extRdata);
    else passCount++;
    pushExp(1'b0, 1'b1, 16'h1234);
    access(1'b0, 1'b0, 16'h0100, 16'h0000, ackCyc, reCnt, weCnt, stallCnt);
    checkCount++;
    if (reCnt !== 3 || ackCyc !== 4 || stallCnt !== 4)
      $display("FAIL rd_timing: got re=%0d ack=%0d stall=%0d expected 3 4 4",
               reCnt, ackCyc, stallCnt);
    else passCount++;
  endtask

  task automatic test_contention();
    int n = 0;
    @(posedge clk); #1;
    rst = 1;
    cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0200;
    extReq = 1; extWe = 0; extAddr = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      pushExp(1'b0, 1'b1, 16'hC0DE);
      pushExp(1'b1, 1'b1, 16'hE0E0);
    end
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (cpuAck || extAck) n++;
      @(posedge clk); #1;
      if (n >= 5) cpuReq = 0;
      if (n >= 6) begin extReq = 0; break; end
    end
    cpuReq = 0; extReq = 0;
    repeat (3) @(negedge clk);
    checkCount++;
    if (n !== 6 || sbq.size() !== 0)
      $display("FAIL contention_count: got acks=%0d left=%0d expected 6 0", n, sbq.size());
    else passCount++;
  endtask

  task automatic test_hold_drop();
    int acks = 0, ackCyc = -1;
    pushExp(1'b0, 1'b1, 16'hC0DE);
    @(posedge clk); #1;
    cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0200;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checkCount++;
        if (dmAddr !== 16'h0200 || dmRe !== 1'b1)
          $display("FAIL addr_latched c%0d: got addr=%h re=%b expected 0200 1", c, dmAddr, dmRe);
        else passCount++;
      end
      if (c == 4) begin
        checkCount++;
        if (cpuAck !== 1'b1) $display("FAIL hold_ack: got %b expected 1", cpuAck);
        else passCount++;
      end
      @(posedge clk); #1;
      if (c == 1) cpuAddr = 16'h0300;
      if (c == 4) cpuReq = 0;
    end
    pushExp(1'b1, 1'b1, 16'hE0E0);
    @(posedge clk); #1;
    extReq = 1; extWe = 0; extAddr = 16'h0300;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (extAck) begin acks++; if (ackCyc < 0) ackCyc = c; end
      @(posedge clk); #1;
      if (c == 1) extReq = 0;
    end
    checkCount++;
    if (acks !== 1 || ackCyc !== 4)
      $display("FAIL drop_ack: got acks=%0d at=%0d expected 1 at 4", acks, ackCyc);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic first = 1'bx;
    logic dropC = 0, dropE = 0;
    @(posedge clk); #1;
    cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0200;
    repeat (3) @(negedge clk);
    rst = 1;
    extReq = 1; extWe = 0; extAddr = 16'h0300;
    #1;
    checkCount++;
    if ({cpuAck, extAck, dmRe, dmWe} !== 4'b0000)
      $display("FAIL mid_reset_strobes: got %b expected 0000", {cpuAck, extAck, dmRe, dmWe});
    else passCount++;
    checkCount++;
    if ({dmAddr, cpuRdata, extRdata} !== 48'h0)
      $display("FAIL mid_reset_data: got %h expected 0", {dmAddr, cpuRdata, extRdata});
    else passCount++;
    pushExp(1'b0, 1'b1, 16'hC0DE);
    pushExp(1'b1, 1'b1, 16'hE0E0);
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpuAck || extAck) begin
        if (n == 0) first = extAck;
        n++;
      end
      if (cpuAck) dropC = 1;
      if (extAck) dropE = 1;
      @(posedge clk); #1;
      if (dropC) cpuReq = 0;
      if (dropE) extReq = 0;
      if (n >= 2) break;
    end
    cpuReq = 0; extReq = 0;
    checkCount++;
    if (first !== 1'b0 || n !== 2)
      $display("FAIL post_reset_first: got first_ext=%b acks=%0d expected 0 2", first, n);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    pushExp(1'b0, 1'b1, 16'hC0DE);
    pushExp(1'b0, 1'b1, 16'hE0E0);
    @(posedge clk); #1;
    cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0200;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpuAck) acks++;
      if (c == 4 || c == 9) begin
        checkCount++;
        if (cpuAck !== 1'b1) $display("FAIL b2b_ack c%0d: got %b expected 1", c, cpuAck);
        else passCount++;
      end
      if (c == 4 || c == 5) begin
        checkCount++;
        if (dmRe !== 1'b0) $display("FAIL b2b_no_regrant c%0d: got dm_re=%b expected 0", c, dmRe);
        else passCount++;
      end
      if (c == 6) begin
        checkCount++;
        if (dmRe !== 1'b1 || dmAddr !== 16'h0300)
          $display("FAIL b2b_second_start: got re=%b addr=%h expected 1 0300", dmRe, dmAddr);
        else passCount++;
      end
      @(posedge clk); #1;
      if (c == 4) cpuAddr = 16'h0300;
      if (c == 9) cpuReq = 0;
    end
    checkCount++;
    if (acks !== 2) $display("FAIL b2b_ack_count: got %0d expected 2", acks);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_lat1_read();
    test_write_read();
    test_contention();
    test_hold_drop();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checkCount++;
    if (sbq.size() !== 0) $display("FAIL sb_leftover: got %0d expected 0", sbq.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
